// File: rtl/player_fsm.sv
// Per-player action controller: converts buttons and hit events into a sprite
// state code, x position and hitbox flags, updating once per video frame.
module player_fsm #(
    parameter bit FACE_RIGHT  = 1'b1,
    parameter int START_X     = 100,
    parameter int START_Y     = 300,
    parameter int MIN_X       = 0,
    parameter int MAX_X       = 527,
    parameter int FWD_SPEED   = 3,
    parameter int BACK_SPEED  = 2,
    parameter int KNOCKBACK   = 1,
    parameter int ATK_START_N = 5,
    parameter int ATK_END_N   = 2,
    parameter int ATK_PULL_N  = 16,
    parameter int DIR_START_N = 4,
    parameter int DIR_END_N   = 3,
    parameter int DIR_PULL_N  = 15,
    parameter int HITSTUN_N   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       btn_block,
    input  logic       got_hit,
    output logic [3:0] currentstate,
    output logic [9:0] posx,
    output logic [9:0] posy,
    output logic       hit_active,
    output logic       hit_dir,
    output logic       blocking
);

    localparam int unsigned SW = 4;
    localparam int unsigned XW = 10;
    localparam int unsigned CW = 5;
    localparam int unsigned AW = 12;

    localparam int FWD_STEP  = FACE_RIGHT ? FWD_SPEED : -FWD_SPEED;
    localparam int BACK_STEP = FACE_RIGHT ? -BACK_SPEED : BACK_SPEED;
    localparam int KB_STEP   = FACE_RIGHT ? -KNOCKBACK : KNOCKBACK;

    typedef enum logic [SW-1:0] {
        ST_IDLE   = 4'd0,
        ST_WALK_F = 4'd1,
        ST_WALK_B = 4'd2,
        ST_ATK_S  = 4'd3,
        ST_ATK_E  = 4'd4,
        ST_ATK_P  = 4'd5,
        ST_DIR_S  = 4'd6,
        ST_DIR_E  = 4'd7,
        ST_DIR_P  = 4'd8,
        ST_HIT    = 4'd9,
        ST_BLOCK  = 4'd10
    } state_e;

    state_e          state_q, state_d, nxt_state;
    logic [CW-1:0]   fcnt_q, fcnt_d;
    logic            atk_prev_q, atk_prev_d;
    logic [XW-1:0]   posx_q, posx_d;
    logic            hit_active_q, hit_active_d;
    logic            hit_dir_q, hit_dir_d;
    logic            blocking_q, blocking_d;

    logic            fwd, back, atk_edge, cnt_done;
    logic signed [AW-1:0] step, pos_sum;
    logic [XW-1:0]   pos_sat;

    function automatic logic is_timed(input state_e s);
        return s inside {ST_ATK_S, ST_ATK_E, ST_ATK_P, ST_DIR_S, ST_DIR_E, ST_DIR_P, ST_HIT};
    endfunction

    // Count loaded on entry; the state then lasts exactly N ticks.
    function automatic logic [CW-1:0] entry_count(input state_e s);
        case (s)
            ST_ATK_S: return CW'(ATK_START_N - 1);
            ST_ATK_E: return CW'(ATK_END_N - 1);
            ST_ATK_P: return CW'(ATK_PULL_N - 1);
            ST_DIR_S: return CW'(DIR_START_N - 1);
            ST_DIR_E: return CW'(DIR_END_N - 1);
            ST_DIR_P: return CW'(DIR_PULL_N - 1);
            ST_HIT:   return CW'(HITSTUN_N - 1);
            default:  return '0;
        endcase
    endfunction

    assign fwd      = FACE_RIGHT ? btn_right : btn_left;
    assign back     = FACE_RIGHT ? btn_left  : btn_right;
    assign atk_edge = btn_attack & ~atk_prev_q;
    assign cnt_done = (fcnt_q == '0);

    // Next-state selection; hits preempt everything except hitstun and block.
    always_comb begin
        nxt_state = state_q;
        if (got_hit && state_q != ST_HIT && state_q != ST_BLOCK) begin
            nxt_state = ST_HIT;
        end else if (got_hit && state_q == ST_BLOCK) begin
            nxt_state = ST_BLOCK;
        end else begin
            case (state_q)
                ST_IDLE, ST_WALK_F, ST_WALK_B: begin
                    if (btn_block)          nxt_state = ST_BLOCK;
                    else if (atk_edge && fwd) nxt_state = ST_DIR_S;
                    else if (atk_edge)      nxt_state = ST_ATK_S;
                    else if (fwd && !back)  nxt_state = ST_WALK_F;
                    else if (back && !fwd)  nxt_state = ST_WALK_B;
                    else                    nxt_state = ST_IDLE;
                end
                ST_ATK_S: nxt_state = cnt_done ? ST_ATK_E : ST_ATK_S;
                ST_ATK_E: nxt_state = cnt_done ? ST_ATK_P : ST_ATK_E;
                ST_ATK_P: nxt_state = cnt_done ? ST_IDLE  : ST_ATK_P;
                ST_DIR_S: nxt_state = cnt_done ? ST_DIR_E : ST_DIR_S;
                ST_DIR_E: nxt_state = cnt_done ? ST_DIR_P : ST_DIR_E;
                ST_DIR_P: nxt_state = cnt_done ? ST_IDLE  : ST_DIR_P;
                ST_HIT:   nxt_state = cnt_done ? ST_IDLE  : ST_HIT;
                ST_BLOCK: nxt_state = btn_block ? ST_BLOCK : ST_IDLE;
                default:  nxt_state = ST_IDLE;
            endcase
        end
    end

    // Movement for the upcoming state, saturated to the playfield.
    always_comb begin
        case (nxt_state)
            ST_WALK_F: step = AW'(FWD_STEP);
            ST_WALK_B: step = AW'(BACK_STEP);
            ST_HIT:    step = AW'(KB_STEP);
            default:   step = '0;
        endcase
        pos_sum = $signed({2'b00, posx_q}) + step;
        if (pos_sum < AW'(MIN_X))      pos_sat = XW'(MIN_X);
        else if (pos_sum > AW'(MAX_X)) pos_sat = XW'(MAX_X);
        else                           pos_sat = XW'(pos_sum);
    end

    // Register updates happen only on frame ticks.
    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        atk_prev_d   = atk_prev_q;
        posx_d       = posx_q;
        hit_active_d = hit_active_q;
        hit_dir_d    = hit_dir_q;
        blocking_d   = blocking_q;
        if (frame_tick) begin
            state_d    = nxt_state;
            atk_prev_d = btn_attack;
            posx_d     = pos_sat;
            if (nxt_state != state_q && is_timed(nxt_state)) begin
                fcnt_d = entry_count(nxt_state);
            end else if (is_timed(nxt_state)) begin
                fcnt_d = fcnt_q - CW'(1);
            end else begin
                fcnt_d = '0;
            end
            hit_active_d = (nxt_state == ST_ATK_E) || (nxt_state == ST_DIR_E);
            hit_dir_d    = (nxt_state == ST_DIR_E);
            blocking_d   = (nxt_state == ST_BLOCK);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fcnt_q       <= '0;
            atk_prev_q   <= 1'b1;
            posx_q       <= XW'(START_X);
            hit_active_q <= 1'b0;
            hit_dir_q    <= 1'b0;
            blocking_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            atk_prev_q   <= atk_prev_d;
            posx_q       <= posx_d;
            hit_active_q <= hit_active_d;
            hit_dir_q    <= hit_dir_d;
            blocking_q   <= blocking_d;
        end
    end

    assign currentstate = state_q;
    assign posx         = posx_q;
    assign posy         = XW'(START_Y);
    assign hit_active   = hit_active_q;
    assign hit_dir      = hit_dir_q;
    assign blocking     = blocking_q;

endmodule

// File: tb/tb_player_fsm.sv
// Bench for player_fsm: directed scenarios plus random button traffic,
// checked against a table-driven behavioural model of one player.
module tb_player_fsm;

    localparam int START_X = 100;
    localparam int START_Y = 300;
    localparam int MIN_X   = 0;
    localparam int MAX_X   = 527;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_attack = 1'b0, btn_block = 1'b0;
    logic       got_hit = 1'b0;
    logic [3:0] currentstate;
    logic [9:0] posx, posy;
    logic       hit_active, hit_dir, blocking;

    int total = 0;
    int bad   = 0;

    // Model: state code, ticks left in a timed state, position, previous attack level.
    int m_state, m_left, m_pos, m_prev;
    int dur_tab   [0:10] = '{0, 0, 0, 5, 2, 16, 4, 3, 15, 15, 0};
    int chain_tab [0:10] = '{0, 0, 0, 4, 5, 0, 7, 8, 0, 0, 0};

    player_fsm dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right),
        .btn_attack(btn_attack), .btn_block(btn_block), .got_hit(got_hit),
        .currentstate(currentstate), .posx(posx), .posy(posy),
        .hit_active(hit_active), .hit_dir(hit_dir), .blocking(blocking)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_left = 0; m_pos = START_X; m_prev = 1;
    endfunction

    function automatic void model_step();
        int  nxt;
        bit  edge_a, fwd, back;
        fwd    = btn_right;
        back   = btn_left;
        edge_a = btn_attack && !m_prev;
        m_prev = btn_attack;
        if (got_hit && m_state != 9 && m_state != 10) nxt = 9;
        else if (got_hit && m_state == 10)            nxt = 10;
        else if (m_state <= 2) begin
            if (btn_block)            nxt = 10;
            else if (edge_a && fwd)   nxt = 6;
            else if (edge_a)          nxt = 3;
            else if (fwd && !back)    nxt = 1;
            else if (back && !fwd)    nxt = 2;
            else                      nxt = 0;
        end else if (m_state == 10)   nxt = btn_block ? 10 : 0;
        else                          nxt = (m_left == 1) ? chain_tab[m_state] : m_state;

        if (nxt != m_state && dur_tab[nxt] != 0) m_left = dur_tab[nxt];
        else if (dur_tab[nxt] != 0)              m_left--;
        else                                     m_left = 0;

        if (nxt == 1) m_pos += 3;
        if (nxt == 2) m_pos -= 2;
        if (nxt == 9) m_pos -= 1;
        if (m_pos < MIN_X) m_pos = MIN_X;
        if (m_pos > MAX_X) m_pos = MAX_X;
        m_state = nxt;
    endfunction

    task automatic check_all(input string ctx);
        chk({ctx, ".state"},  int'(currentstate), m_state);
        chk({ctx, ".posx"},   int'(posx), m_pos);
        chk({ctx, ".posy"},   int'(posy), START_Y);
        chk({ctx, ".hitact"}, int'(hit_active), int'(m_state == 4 || m_state == 7));
        chk({ctx, ".hitdir"}, int'(hit_dir), int'(m_state == 7));
        chk({ctx, ".block"},  int'(blocking), int'(m_state == 10));
    endtask

    // One frame tick, then a few quiet cycles over which every output must hold.
    task automatic tick(input string ctx, input int gap);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_step();
        check_all(ctx);
        for (int g = 0; g < gap; g++) @(negedge clk);
        if (gap > 0) check_all({ctx, ".hold"});
    endtask

    task automatic ticks(input string ctx, input int n);
        for (int i = 0; i < n; i++) tick(ctx, 0);
    endtask

    // Async reset asserted mid-frame; outputs must return before any clock edge.
    task automatic apply_reset(input string ctx);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all({ctx, ".async"});
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check_all({ctx, ".tickinrst"});
        rst = 1'b0;
    endtask

    task automatic set_btn(input bit l, input bit r, input bit a, input bit b, input bit h);
        btn_left = l; btn_right = r; btn_attack = a; btn_block = b; got_hit = h;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        set_btn(0, 1, 0, 0, 0);  ticks("walk_fwd", 10);
        chk("walk_fwd.pos130", int'(posx), 130);
        set_btn(1, 0, 0, 0, 0);  ticks("walk_back_clamp", 70);
        chk("walk_back.min", int'(posx), 0);
        set_btn(0, 1, 0, 0, 0);  ticks("walk_fwd_clamp", 180);
        chk("walk_fwd.max", int'(posx), MAX_X);
        set_btn(0, 0, 0, 0, 0);  ticks("idle", 2);

        set_btn(0, 0, 1, 0, 0);  ticks("atk_held", 30);
        set_btn(0, 0, 0, 0, 0);  ticks("atk_rel", 1);
        set_btn(0, 0, 1, 0, 0);  ticks("atk_repress", 1);
        chk("atk_repress.state3", int'(currentstate), 3);
        set_btn(0, 0, 0, 0, 0);  ticks("atk_run", 25);

        set_btn(0, 1, 1, 0, 0);  ticks("dir_start", 1);
        chk("dir_start.state6", int'(currentstate), 6);
        set_btn(0, 1, 0, 0, 0);  ticks("dir_run", 25);

        set_btn(0, 0, 1, 0, 0);  ticks("hit_atk", 1);
        set_btn(0, 0, 0, 0, 0);  ticks("hit_atk2", 2);
        set_btn(0, 0, 0, 0, 1);  ticks("hit_preempt", 1);
        chk("hit_preempt.state9", int'(currentstate), 9);
        set_btn(0, 0, 0, 0, 0);  ticks("hitstun", 18);

        set_btn(0, 0, 0, 1, 0);  ticks("block", 2);
        set_btn(0, 0, 0, 1, 1);  ticks("block_hit", 5);
        set_btn(0, 0, 0, 0, 1);  ticks("block_hit_rel", 2);
        set_btn(0, 0, 0, 0, 0);  ticks("post_block", 16);

        set_btn(0, 1, 1, 0, 0);  ticks("rst_dir", 1);
        set_btn(0, 1, 0, 0, 0);  ticks("rst_dir2", 9);
        chk("rst_dir.state8", int'(currentstate), 8);
        set_btn(0, 0, 1, 0, 0);
        apply_reset("rst_mid");
        ticks("held_atk_after_rst", 1);
        chk("held_atk.idle", int'(currentstate), 0);

        // Random traffic with held-button runs, sparse hits and rare resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                set_btn(1'($urandom), 1'($urandom), 1'($urandom),
                        1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0));
            else
                got_hit = 1'($urandom_range(0, 12) == 0);
            if ($urandom_range(0, 199) == 0) apply_reset("rnd_rst");
            tick("rnd", int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_fsm.md
# player_fsm

Per-player action controller that sits directly upstream of the sprite renderer. Once per video frame it turns one player's button inputs and hit events into the sprite state code `currentstate`, the sprite position `posx`/`posy` and the hitbox flags. Two instances are used, one per player, and together they drive the renderer's `currentstate`/`posx`/`posy` and `currentstate2`/`posx2`/`posy2` inputs.

## Interface
Parameters:
- FACE_RIGHT, 1: 1 = forward is `btn_right` and +x; 0 = forward is `btn_left` and −x
- START_X, 100: `posx` value after reset
- START_Y, 300: constant value driven on `posy`
- MIN_X, 0: lower clamp for `posx`
- MAX_X, 527: upper clamp for `posx` (640 − 113 sprite width)
- FWD_SPEED, 3: pixels moved per frame while walking forward
- BACK_SPEED, 2: pixels moved per frame while walking back
- KNOCKBACK, 1: pixels pushed backward per frame while in hitstun
- ATK_START_N / ATK_END_N / ATK_PULL_N, 5 / 2 / 16: frames spent in each normal-attack phase
- DIR_START_N / DIR_END_N / DIR_PULL_N, 4 / 3 / 15: frames spent in each directional-attack phase
- HITSTUN_N, 15: frames spent in the got-hit state

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-clk pulse per frame; the block updates only on cycles where this is high
- btn_left, btn_right, btn_attack, btn_block  in  1 each  button levels, already synchronous to `clk`
- got_hit  in  1  level from the collision checker: the opponent's hitbox overlaps this player
- currentstate  out  4  sprite state code, encoding listed under Operation
- posx  out  10  sprite x position
- posy  out  10  sprite y position, always START_Y
- hit_active  out  1  high in states 4 and 7 (attack hitbox live)
- hit_dir  out  1  high in state 7 only
- blocking  out  1  high in state 10

## Operation
- State encoding (fixed, must match the renderer):
  - 0 idle, 1 walk forward, 2 walk back
  - 3 attack start, 4 attack end, 5 attack pull
  - 6 directional attack start, 7 directional attack end, 8 directional attack pull
  - 9 got hit, 10 block
  - Codes 11–15 are never produced.
- `fwd`/`back` are `btn_right`/`btn_left` when FACE_RIGHT=1, swapped when FACE_RIGHT=0.
- Attack edge: `atk_edge = btn_attack & ~atk_prev`. `atk_prev` is loaded with `btn_attack` on every frame_tick and resets to 1, so an attack held through reset does not fire.
- Frame counter `fcnt` (5 bits):
  - Loaded with N−1 when a timed state (3–9) is entered.
  - Decremented on each tick while in that state.
  - The state advances on the tick where `fcnt` is 0, so every timed state lasts exactly N ticks.
- Next-state rules on each frame_tick, in priority order:
  1. `got_hit` while in any state other than 9 or 10 → 9. This preempts attack phases.
  2. `got_hit` while in 10 → stay in 10 (blocked). `got_hit` while in 9 → ignored; hitstun is not restarted.
  3. States 0/1/2:
     - `btn_block` → 10
     - else `atk_edge & fwd` → 6
     - else `atk_edge` → 3
     - else `fwd & ~back` → 1
     - else `back & ~fwd` → 2
     - else → 0
  4. Timed chains: 3→4→5→0 and 6→7→8→0. 9→0 when its count expires.
  5. State 10 → 0 on the first tick with `btn_block` low.
- Position is updated on the same tick, using the next state:
  - +FWD_SPEED×dir when next state is 1.
  - −BACK_SPEED×dir when next state is 2.
  - −KNOCKBACK×dir for every tick spent in 9, including the entry tick.
  - Arithmetic is done signed in 12 bits, then saturated to [MIN_X, MAX_X]. No wrap at 0 or 1023.
- `hit_active`, `hit_dir` and `blocking` are decoded from the registered state.

## Timing
- All outputs are registered and change only on a `clk` edge where frame_tick=1; with frame_tick low, every register holds.
- Latency: inputs are sampled at the frame_tick edge and the new outputs are visible from that edge onward. Outputs are stable for the whole following frame.
- Reset values: `currentstate`=0, `posx`=START_X, `posy`=START_Y, `hit_active`=0, `hit_dir`=0, `blocking`=0, `fcnt`=0, `atk_prev`=1.
- An `rst` assertion mid-attack or mid-hitstun returns all of the above immediately; the interrupted sequence does not resume.
- frame_tick during rst is ignored.

## Test plan
- Reset, then hold `btn_right` for 10 ticks (FACE_RIGHT=1) → `currentstate`=1 from tick 1; `posx` = 100, 103, …, 130.
- Hold `btn_left` from `posx`=1 → `posx`=0 on the next tick, stays 0, no wrap; `currentstate`=2.
- One-tick `btn_attack` pulse from idle → states 3 for 5 ticks, 4 for 2 ticks (`hit_active`=1, `hit_dir`=0), 5 for 16 ticks, then 0. Holding attack does not re-fire until it is released and pressed again.
- `btn_attack` rising with `btn_right` held → 6×4, 7×3 (`hit_dir`=1), 8×15, then 0.
- `got_hit` asserted during state 3 → next tick state 9, `posx` −1 per tick for 15 ticks, then 0. The same `got_hit` while in state 10 → stays 10, `posx` unchanged.
- Assert `rst` during state 8 → immediately state 0, `posx`=100. Hold `btn_attack` through reset release → no attack on the first tick.
